// File: rtl/hwag_ign_channel.sv
// hwag_ign_channel: per-cylinder ignition coil driver fed by the hwag_core angle count.
// The coil is charged from the dwell angle to the spark angle, and a clk-based max-dwell
// timer cuts it off as a safety measure. Host angle writes are double-buffered and are only
// applied at a revolution boundary, so one revolution never mixes old and new settings.
// Optional build macro: HWAG_IGN_DWELL_MEAS_EN (registers the measured dwell on dwell_meas).
module hwag_ign_channel #(
  parameter int ACNT_WIDTH = 24,
  parameter int ACNT_TOP   = 3839,
  parameter int TMR_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hwag_start,
  input  logic [ACNT_WIDTH-1:0] acnt,
  input  logic                  angle_tick,
  input  logic                  cfg_wr,
  input  logic [ACNT_WIDTH-1:0] cfg_dwell_angle,
  input  logic [ACNT_WIDTH-1:0] cfg_spark_angle,
  input  logic [TMR_WIDTH-1:0]  cfg_max_dwell,
  output logic                  coil_out,
  output logic                  cfg_pending,
  output logic                  fault_timeout,
  output logic [1:0]            state_out,
  output logic [TMR_WIDTH-1:0]  dwell_meas
);

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_WAIT  = 2'b01,
    S_DWELL = 2'b10,
    S_SPARK = 2'b11
  } state_t;

  localparam logic [ACNT_WIDTH-1:0] ANGLE_TOP = ACNT_WIDTH'(ACNT_TOP);
  localparam logic [TMR_WIDTH-1:0]  TMR_ONE   = TMR_WIDTH'(1);

  state_t                state;
  logic [TMR_WIDTH-1:0]  timer;
  logic [ACNT_WIDTH-1:0] act_dwell, act_spark, sh_dwell, sh_spark;
  logic [TMR_WIDTH-1:0]  act_max, sh_max;
  logic                  apply_defer;

  logic                  wrap, hit_d, hit_s, timeout;
  logic                  dwell_exit, apply_evt;
  logic [TMR_WIDTH-1:0]  timer_inc;

  // Angle events, cutoff detection and the shadow-apply opportunity for this cycle.
  always_comb begin
    wrap       = angle_tick && (acnt == '0);
    hit_d      = angle_tick && (acnt == act_dwell) && (act_dwell <= ANGLE_TOP);
    hit_s      = angle_tick && (acnt == act_spark) && (act_spark <= ANGLE_TOP);
    timeout    = (act_max != '0) && (timer == (act_max - TMR_ONE));
    timer_inc  = (timer == '1) ? timer : (timer + TMR_ONE);
    dwell_exit = (state == S_DWELL) && (!hwag_start || hit_s || timeout);
    // A wrap seen while charging postpones the apply until the dwell window closes.
    apply_evt  = (state == S_OFF)
              || (wrap && (state != S_DWELL))
              || (dwell_exit && (apply_defer || wrap));
  end

  assign state_out = state;

  // Channel sequencer: coil drive, dwell timer and the sticky cutoff flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_OFF;
      coil_out      <= 1'b0;
      timer         <= '0;
      fault_timeout <= 1'b0;
    end else begin
      if (cfg_wr) begin
        fault_timeout <= 1'b0;
      end
      if (!hwag_start) begin
        state    <= S_OFF;
        coil_out <= 1'b0;
      end else begin
        case (state)
          S_OFF: begin
            coil_out <= 1'b0;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            coil_out <= 1'b0;
            if (hit_d && (act_dwell != act_spark)) begin
              state    <= S_DWELL;
              coil_out <= 1'b1;
              timer    <= '0;
            end
          end
          S_DWELL: begin
            coil_out <= 1'b1;
            timer    <= timer_inc;
            if (hit_s) begin
              state    <= S_SPARK;
              coil_out <= 1'b0;
            end else if (timeout) begin
              state         <= S_SPARK;
              coil_out      <= 1'b0;
              fault_timeout <= 1'b1;
            end
          end
          S_SPARK: begin
            coil_out <= 1'b0;
            if (angle_tick) begin
              state <= S_WAIT;
            end
          end
          default: begin
            state    <= S_OFF;
            coil_out <= 1'b0;
          end
        endcase
      end
    end
  end

  // Double-buffered configuration: host writes land in shadow, move to active at a boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_dwell   <= '0;
      act_spark   <= '0;
      act_max     <= '0;
      sh_dwell    <= '0;
      sh_spark    <= '0;
      sh_max      <= '0;
      cfg_pending <= 1'b0;
      apply_defer <= 1'b0;
    end else begin
      if (cfg_wr) begin
        sh_dwell <= cfg_dwell_angle;
        sh_spark <= cfg_spark_angle;
        sh_max   <= cfg_max_dwell;
        if (apply_evt) begin
          act_dwell   <= cfg_dwell_angle;
          act_spark   <= cfg_spark_angle;
          act_max     <= cfg_max_dwell;
          cfg_pending <= 1'b0;
        end else begin
          cfg_pending <= 1'b1;
        end
      end else if (apply_evt && cfg_pending) begin
        act_dwell   <= sh_dwell;
        act_spark   <= sh_spark;
        act_max     <= sh_max;
        cfg_pending <= 1'b0;
      end
      if (apply_evt) begin
        apply_defer <= 1'b0;
      end else if (wrap && (state == S_DWELL) && (cfg_pending || cfg_wr)) begin
        apply_defer <= 1'b1;
      end
    end
  end

`ifdef HWAG_IGN_DWELL_MEAS_EN
  // Capture coil-on time at every dwell end, except when the dwell was killed by loss of sync.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_meas <= '0;
    end else if (dwell_exit && hwag_start) begin
      dwell_meas <= timer_inc;
    end
  end
`else
  assign dwell_meas = '0;
`endif

endmodule

// File: tb/tb_hwag_ign_channel.sv
// tb_hwag_ign_channel: directed bench for hwag_ign_channel (dwell/spark sequencing,
// wrap-crossing dwell, max-dwell cutoff, shadow apply timing, reset and loss of sync).
module tb_hwag_ign_channel;

  localparam int AW  = 24;
  localparam int TW  = 24;
  localparam int TOP = 3839;

`ifdef HWAG_IGN_DWELL_MEAS_EN
  localparam bit MEAS_ON = 1'b1;
`else
  localparam bit MEAS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hwag_start = 1'b0;
  logic [AW-1:0] acnt = '0;
  logic          angle_tick = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [AW-1:0] cfg_dwell_angle = '0;
  logic [AW-1:0] cfg_spark_angle = '0;
  logic [TW-1:0] cfg_max_dwell = '0;
  logic          coil_out;
  logic          cfg_pending;
  logic          fault_timeout;
  logic [1:0]    state_out;
  logic [TW-1:0] dwell_meas;

  int checks   = 0;
  int failures = 0;

  int   coil_hi_cnt = 0;
  int   pulse_cnt   = 0;
  logic coil_prev   = 1'b0;
  logic cnt_clr     = 1'b0;

  hwag_ign_channel #(
    .ACNT_WIDTH(AW),
    .ACNT_TOP  (TOP),
    .TMR_WIDTH (TW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hwag_start     (hwag_start),
    .acnt           (acnt),
    .angle_tick     (angle_tick),
    .cfg_wr         (cfg_wr),
    .cfg_dwell_angle(cfg_dwell_angle),
    .cfg_spark_angle(cfg_spark_angle),
    .cfg_max_dwell  (cfg_max_dwell),
    .coil_out       (coil_out),
    .cfg_pending    (cfg_pending),
    .fault_timeout  (fault_timeout),
    .state_out      (state_out),
    .dwell_meas     (dwell_meas)
  );

  always #5 clk = ~clk;

  // Count coil-on clock cycles and rising coil edges, sampled mid-cycle.
  always @(negedge clk) begin
    if (cnt_clr) begin
      coil_hi_cnt <= 0;
      pulse_cnt   <= 0;
    end else begin
      if (coil_out === 1'b1) coil_hi_cnt <= coil_hi_cnt + 1;
      if (coil_out === 1'b1 && coil_prev === 1'b0) pulse_cnt <= pulse_cnt + 1;
    end
    coil_prev <= coil_out;
  end

  function automatic int meas(input int v);
    return MEAS_ON ? v : 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int dwell, input int spark, input int maxd);
    cfg_dwell_angle = AW'(dwell);
    cfg_spark_angle = AW'(spark);
    cfg_max_dwell   = TW'(maxd);
    cfg_wr          = 1'b1;
    @(posedge clk);
    #1;
    cfg_wr = 1'b0;
  endtask

  task automatic stepTick();
    acnt       = (acnt == AW'(TOP)) ? '0 : acnt + AW'(1);
    angle_tick = 1'b1;
    @(posedge clk);
    #1;
    angle_tick = 1'b0;
  endtask

  task automatic slowTick();
    stepTick();
    idle(3);
  endtask

  task automatic slowTo(input int target);
    int n = 0;
    while (int'(acnt) != target && n < 4000) begin
      slowTick();
      n++;
    end
    if (int'(acnt) != target) begin
      checks++;
      failures++;
      $display("[TB] FAIL slowTo observed=%0d expected=%0d", acnt, target);
    end
  endtask

  task automatic fastTo(input int target);
    int n = 0;
    while (int'(acnt) != target && n < 4000) begin
      stepTick();
      n++;
    end
    if (int'(acnt) != target) begin
      checks++;
      failures++;
      $display("[TB] FAIL fastTo observed=%0d expected=%0d", acnt, target);
    end
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_coil", 32'(coil_out), 0);
    checkOutput("rst_state", 32'(state_out), 0);
    checkOutput("rst_pending", 32'(cfg_pending), 0);
    checkOutput("rst_fault", 32'(fault_timeout), 0);
    checkOutput("rst_meas", 32'(dwell_meas), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);
    checkOutput("rst_stay_off", 32'(state_out), 0);

    // Basic dwell 3000 -> spark 3200, ticks every 4 clk
    $display("[TB] basic dwell window");
    applyStimulus(3000, 3200, 0);
    checkOutput("t2_pending_off", 32'(cfg_pending), 0);
    acnt = AW'(2990);
    hwag_start = 1'b1;
    idle(1);
    checkOutput("t2_wait", 32'(state_out), 1);
    slowTo(2999);
    checkOutput("t2_coil_pre", 32'(coil_out), 0);
    cnt_clr = 1'b1;
    stepTick();
    cnt_clr = 1'b0;
    checkOutput("t2_coil_rise", 32'(coil_out), 1);
    checkOutput("t2_dwell", 32'(state_out), 2);
    idle(3);
    slowTo(3199);
    checkOutput("t2_coil_hold", 32'(coil_out), 1);
    stepTick();
    checkOutput("t2_coil_fall", 32'(coil_out), 0);
    checkOutput("t2_spark", 32'(state_out), 3);
    checkOutput("t2_hi_cycles", 32'(coil_hi_cnt), 800);
    checkOutput("t2_meas", 32'(dwell_meas), 32'(meas(800)));
    checkOutput("t2_fault", 32'(fault_timeout), 0);
    idle(3);
    slowTick();
    checkOutput("t2_back_wait", 32'(state_out), 1);

    // Dwell window crossing the revolution wrap
    $display("[TB] wrap-crossing dwell");
    applyStimulus(3800, 100, 0);
    checkOutput("t3_pending", 32'(cfg_pending), 1);
    acnt = AW'(3835);
    fastTo(0);
    checkOutput("t3_applied", 32'(cfg_pending), 0);
    acnt = AW'(3795);
    slowTo(3799);
    checkOutput("t3_coil_pre", 32'(coil_out), 0);
    cnt_clr = 1'b1;
    stepTick();
    cnt_clr = 1'b0;
    checkOutput("t3_coil_rise", 32'(coil_out), 1);
    idle(3);
    slowTo(99);
    checkOutput("t3_coil_across_wrap", 32'(coil_out), 1);
    stepTick();
    checkOutput("t3_coil_fall", 32'(coil_out), 0);
    checkOutput("t3_hi_cycles", 32'(coil_hi_cnt), 560);
    checkOutput("t3_meas", 32'(dwell_meas), 32'(meas(560)));
    idle(3);
    fastTo(3799);
    checkOutput("t3_one_pulse", 32'(pulse_cnt), 1);
    checkOutput("t3_coil_idle", 32'(coil_out), 0);
    hwag_start = 1'b0;
    idle(1);
    checkOutput("t3_off", 32'(state_out), 0);

    // Max-dwell cutoff at 50 clk
    $display("[TB] max-dwell cutoff");
    applyStimulus(1000, 1500, 50);
    acnt = AW'(995);
    hwag_start = 1'b1;
    idle(1);
    slowTo(999);
    cnt_clr = 1'b1;
    stepTick();
    cnt_clr = 1'b0;
    checkOutput("t4_coil_rise", 32'(coil_out), 1);
    idle(3);
    repeat (12) slowTick();
    checkOutput("t4_spark_early", 32'(state_out), 3);
    checkOutput("t4_coil_cut", 32'(coil_out), 0);
    checkOutput("t4_fault_set", 32'(fault_timeout), 1);
    checkOutput("t4_hi_cycles", 32'(coil_hi_cnt), 50);
    checkOutput("t4_meas", 32'(dwell_meas), 32'(meas(50)));
    slowTick();
    checkOutput("t4_wait", 32'(state_out), 1);
    fastTo(1500);
    checkOutput("t4_spark_ignored", 32'(state_out), 1);
    checkOutput("t4_coil_low", 32'(coil_out), 0);
    fastTo(999);
    stepTick();
    checkOutput("t4_redwell", 32'(coil_out), 1);
    checkOutput("t4_fault_sticky", 32'(fault_timeout), 1);
    idle(5);

    // Asynchronous reset mid-dwell
    $display("[TB] async reset mid-dwell");
    hwag_start = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("t1_coil", 32'(coil_out), 0);
    checkOutput("t1_state", 32'(state_out), 0);
    checkOutput("t1_fault", 32'(fault_timeout), 0);
    idle(2);
    rst = 1'b1;
    idle(3);
    checkOutput("t1_stay_off", 32'(state_out), 0);
    hwag_start = 1'b1;
    idle(1);
    checkOutput("t1_wait", 32'(state_out), 1);
    hwag_start = 1'b0;
    idle(1);
    checkOutput("t1_off_again", 32'(state_out), 0);

    // cfg_wr clears a set fault flag
    $display("[TB] fault clear by cfg_wr");
    applyStimulus(1000, 1500, 50);
    checkOutput("t4b_direct", 32'(cfg_pending), 0);
    acnt = AW'(999);
    hwag_start = 1'b1;
    idle(1);
    stepTick();
    idle(60);
    checkOutput("t4b_spark", 32'(state_out), 3);
    checkOutput("t4b_fault", 32'(fault_timeout), 1);
    applyStimulus(1000, 1500, 50);
    checkOutput("t4b_fault_clr", 32'(fault_timeout), 0);
    checkOutput("t4b_pending", 32'(cfg_pending), 1);

    // Shadow write during a dwell that crosses the wrap
    $display("[TB] deferred shadow apply");
    hwag_start = 1'b0;
    idle(2);
    checkOutput("t5_off_apply", 32'(cfg_pending), 0);
    applyStimulus(3000, 1500, 0);
    acnt = AW'(2999);
    hwag_start = 1'b1;
    idle(1);
    stepTick();
    checkOutput("t5_dwell", 32'(coil_out), 1);
    applyStimulus(3000, 1600, 0);
    checkOutput("t5_pending", 32'(cfg_pending), 1);
    acnt = AW'(3838);
    fastTo(0);
    checkOutput("t5_pending_wrap", 32'(cfg_pending), 1);
    checkOutput("t5_coil_wrap", 32'(coil_out), 1);
    fastTo(1499);
    checkOutput("t5_coil_1499", 32'(coil_out), 1);
    stepTick();
    checkOutput("t5_old_spark", 32'(coil_out), 0);
    checkOutput("t5_spark_state", 32'(state_out), 3);
    checkOutput("t5_applied", 32'(cfg_pending), 0);
    fastTo(3000);
    checkOutput("t5_dwell2", 32'(coil_out), 1);
    fastTo(1500);
    checkOutput("t5_new_no_1500", 32'(coil_out), 1);
    fastTo(1600);
    checkOutput("t5_new_spark", 32'(coil_out), 0);
    checkOutput("t5_meas", 32'(dwell_meas), 32'(meas(2440)));

    // Loss of sync during dwell
    $display("[TB] loss of sync mid-dwell");
    fastTo(3000);
    fastTo(1200);
    checkOutput("t6_dwell", 32'(state_out), 2);
    hwag_start = 1'b0;
    idle(1);
    checkOutput("t6_coil", 32'(coil_out), 0);
    checkOutput("t6_state", 32'(state_out), 0);
    checkOutput("t6_fault", 32'(fault_timeout), 0);
    checkOutput("t6_meas_hold", 32'(dwell_meas), 32'(meas(2440)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
